// File: rtl/operand_read_pkg.sv
// Shared types and sizing for the operand-fetch sequencer.
package operand_read_pkg;

   localparam int REG_COUNT = 8;
   localparam int REG_IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ_A = 2'd1,
      READ_B = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/operand_read_reg_mux8.sv
// Combinational 8:1 register-file read select.
module reg_mux8
   import operand_read_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]     reg0,
   input  logic [WIDTH-1:0]     reg1,
   input  logic [WIDTH-1:0]     reg2,
   input  logic [WIDTH-1:0]     reg3,
   input  logic [WIDTH-1:0]     reg4,
   input  logic [WIDTH-1:0]     reg5,
   input  logic [WIDTH-1:0]     reg6,
   input  logic [WIDTH-1:0]     reg7,
   input  logic [REG_IDX_W-1:0] sel,
   output logic [WIDTH-1:0]     dout
);

   always_comb begin
      dout = reg0;
      case (sel)
         3'd0: dout = reg0;
         3'd1: dout = reg1;
         3'd2: dout = reg2;
         3'd3: dout = reg3;
         3'd4: dout = reg4;
         3'd5: dout = reg5;
         3'd6: dout = reg6;
         3'd7: dout = reg7;
         default: dout = reg0;
      endcase
   end

endmodule

// File: rtl/operand_read.sv
// Operand-fetch sequencer: reads Rn into A, then Rm into B, then pulses done.
// Optional macro READ_FWD_EN: capture write-port data when it targets readnum.
//
// state  | meaning
// IDLE   | waiting for start
// READ_A | readnum = rn, A captured at end of cycle
// READ_B | readnum = rm, B captured at end of cycle
// DONE   | done pulse, A/B valid; start here chains the next fetch
module operand_read
   import operand_read_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [REG_IDX_W-1:0] rn,
   input  logic [REG_IDX_W-1:0] rm,
   input  logic                 single,
   input  logic [WIDTH-1:0]     reg0,
   input  logic [WIDTH-1:0]     reg1,
   input  logic [WIDTH-1:0]     reg2,
   input  logic [WIDTH-1:0]     reg3,
   input  logic [WIDTH-1:0]     reg4,
   input  logic [WIDTH-1:0]     reg5,
   input  logic [WIDTH-1:0]     reg6,
   input  logic [WIDTH-1:0]     reg7,
   input  logic                 fwd_write,
   input  logic [REG_IDX_W-1:0] fwd_writenum,
   input  logic [WIDTH-1:0]     fwd_data,
   output logic [REG_IDX_W-1:0] readnum,
   output logic [WIDTH-1:0]     A,
   output logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done
);

   state_t               state_q, state_d;
   logic [REG_IDX_W-1:0] rm_q;
   logic                 single_q;
   logic                 accept;
   logic [WIDTH-1:0]     mux_data;
   logic [WIDTH-1:0]     cap_data;

   reg_mux8 #(.WIDTH(WIDTH)) u_mux (
      .reg0 (reg0),
      .reg1 (reg1),
      .reg2 (reg2),
      .reg3 (reg3),
      .reg4 (reg4),
      .reg5 (reg5),
      .reg6 (reg6),
      .reg7 (reg7),
      .sel  (readnum),
      .dout (mux_data)
   );

`ifdef READ_FWD_EN
   assign cap_data = (fwd_write && (fwd_writenum == readnum)) ? fwd_data : mux_data;
`else
   // Write port is not observed; the controller keeps reads and writes apart.
   assign cap_data = mux_data;
   logic unused_fwd;
   assign unused_fwd = &{1'b0, fwd_write, fwd_writenum, fwd_data};
`endif

   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = READ_A;
         READ_A:  state_d = single_q ? DONE : READ_B;
         READ_B:  state_d = DONE;
         DONE:    state_d = start ? READ_A : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // readnum doubles as the latched rn; it moves to rm only when B is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readnum  <= '0;
         rm_q     <= '0;
         single_q <= 1'b0;
         A        <= '0;
         B        <= '0;
      end else begin
         if (accept) begin
            readnum  <= rn;
            rm_q     <= rm;
            single_q <= single;
         end
         if (state_q == READ_A) begin
            A <= cap_data;
            if (!single_q) readnum <= rm_q;
         end
         if (state_q == READ_B) begin
            B <= cap_data;
         end
      end
   end

   assign busy = (state_q == READ_A) || (state_q == READ_B);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_operand_read.sv
// Directed scoreboard bench for operand_read; honours READ_FWD_EN if defined.
module tb_operand_read;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [2:0]       rn, rm;
   logic             single;
   logic [WIDTH-1:0] regs [8];
   logic             fwd_write;
   logic [2:0]       fwd_writenum;
   logic [WIDTH-1:0] fwd_data;
   logic [2:0]       readnum;
   logic [WIDTH-1:0] A, B;
   logic             busy, done;

   int total = 0;
   int bad   = 0;
   logic [2*WIDTH-1:0] sb [$];

   always #5 clk = ~clk;

   operand_read #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .rn           (rn),
      .rm           (rm),
      .single       (single),
      .reg0         (regs[0]),
      .reg1         (regs[1]),
      .reg2         (regs[2]),
      .reg3         (regs[3]),
      .reg4         (regs[4]),
      .reg5         (regs[5]),
      .reg6         (regs[6]),
      .reg7         (regs[7]),
      .fwd_write    (fwd_write),
      .fwd_writenum (fwd_writenum),
      .fwd_data     (fwd_data),
      .readnum      (readnum),
      .A            (A),
      .B            (B),
      .busy         (busy),
      .done         (done)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_cmp(input string tag);
      logic [2*WIDTH-1:0] e;
      total++;
      assert (sb.size() > 0)
      else begin
         bad++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_A"}, {16'h0, A}, {16'h0, e[2*WIDTH-1:WIDTH]});
         chk({tag, "_B"}, {16'h0, B}, {16'h0, e[WIDTH-1:0]});
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      total++;
      assert (done === 1'b1)
      else begin
         bad++;
         $error("FAIL %s_timeout observed done=%b expected=1", tag, done);
      end
      if (done === 1'b1) pop_cmp(tag);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; rn = '0; rm = '0; single = 1'b0;
      fwd_write = 1'b0; fwd_writenum = '0; fwd_data = '0;
      for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + WIDTH'(i);
      regs[2] = 16'h1234; regs[5] = 16'hABCD; regs[4] = 16'h5555;
      regs[7] = 16'h00FF; regs[1] = 16'h1111; regs[6] = 16'h6666;
      regs[3] = 16'h0001; regs[0] = 16'h0000;
      step();
      chk("rst_A", {16'h0, A}, 32'h0);
      chk("rst_B", {16'h0, B}, 32'h0);
      chk("rst_ctl", {27'h0, readnum, busy, done}, 32'h0);
      rst_n = 1'b1;
      step();

      // basic fetch with cycle-accurate latency
      start = 1'b1; rn = 3'd2; rm = 3'd5; sb.push_back({16'h1234, 16'hABCD});
      step();
      start = 1'b0; rn = 3'd0; rm = 3'd0;
      chk("c1_busy_done", {30'h0, busy, done}, 32'h2);
      chk("c1_readnum", {29'h0, readnum}, 32'd2);
      step();
      chk("c2_A", {16'h0, A}, 32'h1234);
      chk("c2_busy_done", {30'h0, busy, done}, 32'h2);
      chk("c2_readnum", {29'h0, readnum}, 32'd5);
      step();
      chk("c3_busy_done", {30'h0, busy, done}, 32'h1);
      pop_cmp("basic");
      step();
      chk("c4_done", {31'h0, done}, 32'h0);
      chk("c4_readnum_hold", {29'h0, readnum}, 32'd5);

      // rn == rm preloads B with 5555
      start = 1'b1; rn = 3'd4; rm = 3'd4; sb.push_back({16'h5555, 16'h5555});
      step(); start = 1'b0;
      wait_done("same_reg", 6);
      step();

      // single fetch: done in cycle 2, B untouched
      start = 1'b1; single = 1'b1; rn = 3'd7; rm = 3'd2; sb.push_back({16'h00FF, 16'h5555});
      step();
      start = 1'b0; single = 1'b0;
      chk("single_c1_busy", {31'h0, busy}, 32'h1);
      step();
      chk("single_c2_done", {31'h0, done}, 32'h1);
      pop_cmp("single");
      step();

      // start held high: done every third cycle
      start = 1'b1; rn = 3'd1; rm = 3'd6;
      for (int k = 0; k < 4; k++) sb.push_back({16'h1111, 16'h6666});
      for (int c = 1; c <= 12; c++) begin
         step();
         chk($sformatf("b2b_done_c%0d", c), {31'h0, done}, {31'h0, (c % 3) == 0});
         if (done === 1'b1) pop_cmp($sformatf("b2b_c%0d", c));
         if (c == 12) start = 1'b0;
      end
      step();

      // start with new indices mid-fetch is ignored
      start = 1'b1; rn = 3'd1; rm = 3'd6; sb.push_back({16'h1111, 16'h6666});
      step();
      rn = 3'd0; rm = 3'd3;
      chk("ign_readnum_a", {29'h0, readnum}, 32'd1);
      step();
      start = 1'b0;
      chk("ign_readnum_b", {29'h0, readnum}, 32'd6);
      step();
      chk("ign_done", {31'h0, done}, 32'h1);
      pop_cmp("ignore");
      step();

      // write-port forwarding in READ_A
`ifdef READ_FWD_EN
      sb.push_back({16'hBEEF, 16'h0001});
`else
      sb.push_back({16'h0001, 16'h0001});
`endif
      start = 1'b1; rn = 3'd3; rm = 3'd3;
      step();
      start = 1'b0; fwd_write = 1'b1; fwd_writenum = 3'd3; fwd_data = 16'hBEEF;
      step();
      fwd_write = 1'b0;
      wait_done("fwd", 4);
      step();

      // reset during READ_B aborts the fetch
      start = 1'b1; rn = 3'd2; rm = 3'd5;
      step(); start = 1'b0;
      step();
      chk("pre_rst_busy", {31'h0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_A", {16'h0, A}, 32'h0);
      chk("mid_rst_B", {16'h0, B}, 32'h0);
      chk("mid_rst_ctl", {27'h0, readnum, busy, done}, 32'h0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("post_rst_nodone_%0d", c), {31'h0, done}, 32'h0);
      end
      start = 1'b1; rn = 3'd5; rm = 3'd2; sb.push_back({16'hABCD, 16'h1234});
      step(); start = 1'b0;
      wait_done("after_rst", 6);

      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
